pic_ctrl: RTL and testbench
===========================

Name: pic_ctrl

Overview:
- Sequential programmable interrupt controller; replaces the combinational 8-line PIC in front of the RISCV core.
- Latches requests as pending, applies a mask and per-line trigger mode, and resolves priority against the in-service set.
- Presents one interrupt with its number to the core through a req/ack handshake.
- Tracks in-service state until the core signals end-of-interrupt (mret path).

Parameters:
- N_IRQ, 8: number of request lines (2..32).
- ID_W, $clog2(N_IRQ): width of the interrupt number.

Ports:
- clk in 1: system clock.
- rst in 1: reset.
- int_req in N_IRQ: request lines, synchronous to clk.
- int out 1: interrupt request to the core; registered.
- int_num out ID_W: number of the presented interrupt; registered; valid while int=1.
- int_ack in 1: one-cycle pulse from the core; the presented interrupt has been taken.
- eoi in 1: one-cycle pulse from the core; service of the current interrupt is finished.
- cfg_we in 1: configuration write strobe.
- cfg_addr in 2: 0=MASK, 1=PEND, 2=ISR, 3=TRIG.
- cfg_wdata in N_IRQ: write data.
- cfg_rdata out N_IRQ: combinational read of the register at cfg_addr.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: int=0, int_num=0. Registers: mask=0 (all enabled), pend=0, isr=0, trig=all-ones (edge), req_q=0, FSM=IDLE.
- Trigger and pending:
  - req_q holds int_req from the previous cycle.
  - Edge line (trig=1): pend bit sets on int_req & ~req_q.
  - Level line (trig=0): pend bit sets whenever int_req=1.
- Register writes:
  - MASK: written directly; 1 = masked. A masked line still latches pending.
  - PEND: write-1-to-clear.
  - ISR: read-only; writes ignored.
  - TRIG: written directly.
- Priority:
  - Line 0 is highest.
  - eligible = pend & ~mask, restricted to lines strictly higher priority than the highest-priority isr bit (all lines if isr=0).
  - winner = highest-priority eligible line.
- FSM IDLE:
  - Eligible set non-empty -> REQ.
  - On that edge: int<=1, int_num<=winner.
- FSM REQ:
  - int_num stays frozen, even if a higher-priority line arrives.
  - On int_ack: pend[int_num] clears, isr[int_num] sets, int<=0, go to IDLE.
  - Before ack, if the line becomes masked or its pend bit is cleared by software: int<=0, go to IDLE, no isr change.
- Latency:
  - Edge sampled at clock edge k -> pend=1 after k -> int=1 after k+1.
  - After ack at edge j, the next int can rise after edge j+1 (one idle cycle minimum).
- eoi:
  - Clears the highest-priority set isr bit.
  - Ignored when isr=0.
- Simultaneous events:
  - Pending set and clear on the same cycle (ack or W1C): set wins.
  - eoi and int_ack on the same cycle: eoi is applied to the old isr, then the ack bit is set.
  - int_ack in IDLE: ignored.
- Nesting: up to N_IRQ nested levels, by construction of the eligibility rule.
- Reset mid-handshake: everything returns to reset values immediately; int drops asynchronously.

Optional Feature:
- Macro: PIC_ROTATE_PRIO_EN.
- Defined:
  - Adds register prio_base (ID_W bits, reset 0).
  - Priority order is prio_base (highest), prio_base+1, ..., wrapping modulo N_IRQ.
  - On eoi, prio_base <= (cleared line + 1) mod N_IRQ, so the serviced line becomes lowest priority.
  - The isr comparison and eoi's "highest-priority isr bit" both use the rotated order.
- Undefined: fixed order, line 0 highest; no prio_base register.

Decomposition:
- Package pic_pkg:
  - Default N_IRQ.
  - FSM state enum {IDLE, REQ}.
  - cfg address constants CFG_MASK=0, CFG_PEND=1, CFG_ISR=2, CFG_TRIG=3.
- Sub-module pic_prio_enc:
  - Combinational.
  - Inputs: vector, base.
  - Outputs: found flag, index of the highest-priority set bit from base.
  - Used for both the winner and the eoi target.
  - base is tied to 0 when the macro is undefined.

Test Plan:
1. Reset, pulse int_req[5] for 1 cycle -> int=1, int_num=5 two cycles later; int_ack -> int=0, ISR=0x20, PEND=0; eoi -> ISR=0.
2. int_req[6] and [2] rise on the same cycle -> int_num=2; after ack, int_num=6 is not presented until eoi; after eoi, int_num=6.
3. Service line 4 (ISR=0x10), then raise int_req[1] -> nested int_num=1 presented; raise int_req[7] during line-4 service -> no int.
4. Write MASK=0x08, pulse int_req[3] -> PEND=0x08, int stays 0; write MASK=0 -> int_num=3. In REQ, write PEND=0x08 -> int drops, ISR unchanged.
5. TRIG[0]=0, hold int_req[0] high through ack -> PEND[0] re-sets the cycle after ack; assert rst low while int=1 -> int=0, all registers at reset values immediately.
6. PIC_ROTATE_PRIO_EN: service line 0 and eoi, then raise lines 0 and 1 together -> int_num=1.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types, register addresses and priority-order helpers for the interrupt controller.
package pic_pkg;

  localparam int N_IRQ_DEF = 8;

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} pic_state_e;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_PEND = 2'd1;
  localparam logic [1:0] CFG_ISR  = 2'd2;
  localparam logic [1:0] CFG_TRIG = 2'd3;

  // v is always below 2*n here, so one conditional subtract is enough
  function automatic int pic_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

  // position of line idx in the priority order starting at base (0 = highest)
  function automatic int pic_rank(input int idx, input int base, input int n);
    return (idx >= base) ? idx - base : idx + n - base;
  endfunction

endpackage

// File: rtl/pic_ctrl_if.sv
// Core-facing bundle of the interrupt controller: request lines, req/ack/eoi handshake, config port.
interface pic_ctrl_if #(
  parameter int N_IRQ = pic_pkg::N_IRQ_DEF,
  parameter int ID_W  = $clog2(N_IRQ)
);
  logic [N_IRQ-1:0] int_req;
  logic             int_vld;
  logic [ID_W-1:0]  int_num;
  logic             int_ack;
  logic             eoi;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [N_IRQ-1:0] cfg_wdata;
  logic [N_IRQ-1:0] cfg_rdata;

  modport master (
    output int_req, int_ack, eoi, cfg_we, cfg_addr, cfg_wdata,
    input  int_vld, int_num, cfg_rdata
  );

  modport slave (
    input  int_req, int_ack, eoi, cfg_we, cfg_addr, cfg_wdata,
    output int_vld, int_num, cfg_rdata
  );
endinterface

// File: rtl/pic_prio_enc.sv
// Combinational rotating priority encoder: first set bit of vec scanning upward from base, wrapping.
module pic_prio_enc
  import pic_pkg::*;
#(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [ID_W-1:0] base,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = ID_W'(pic_wrap(int'(base) + k, N));
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pic_ctrl.sv
// Sequential PIC: pending/mask/trigger/in-service registers, one interrupt presented via registered int_vld/int_num
// (edge seen at k -> int_vld after k+1); optional rotating priority under PIC_ROTATE_PRIO_EN.
module pic_ctrl
  import pic_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic     clk,
  input  logic     rst,
  pic_ctrl_if.slave bus
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_REQ  = REQ;

  logic [N_IRQ-1:0] mask, pend, isr, trig, req_q;
  logic [N_IRQ-1:0] higher, elig, pend_set, pend_clr, pend_nxt, mask_nxt, isr_clr, isr_set;
  logic [0:0]       state;
  logic             vld_q;
  logic [ID_W-1:0]  num_q;
  logic [ID_W-1:0]  base;
  logic             win_found, isr_found;
  logic [ID_W-1:0]  win_idx, isr_idx;
  logic             ack_take, wr_mask, wr_pend, wr_trig;

  assign ack_take = bus.int_ack && (state == S_REQ);
  assign wr_mask  = bus.cfg_we && (bus.cfg_addr == CFG_MASK);
  assign wr_pend  = bus.cfg_we && (bus.cfg_addr == CFG_PEND);
  assign wr_trig  = bus.cfg_we && (bus.cfg_addr == CFG_TRIG);

`ifdef PIC_ROTATE_PRIO_EN
  // the line just serviced drops to lowest priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      base <= '0;
    else if (bus.eoi && isr_found)
      base <= (isr_idx == ID_W'(N_IRQ - 1)) ? '0 : isr_idx + 1'b1;
  end
`else
  assign base = '0;
`endif

  pic_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_isr_enc (
    .vec(isr), .base(base), .found(isr_found), .idx(isr_idx)
  );

  pic_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_win_enc (
    .vec(elig), .base(base), .found(win_found), .idx(win_idx)
  );

  // only lines strictly above the highest in-service line may interrupt
  always_comb begin
    higher = '0;
    for (int i = 0; i < N_IRQ; i++)
      higher[i] = !isr_found ||
                  (pic_rank(i, int'(base), N_IRQ) < pic_rank(int'(isr_idx), int'(base), N_IRQ));
  end

  assign elig     = pend & ~mask & higher;
  assign pend_set = (trig & bus.int_req & ~req_q) | (~trig & bus.int_req);
  assign pend_nxt = pend_set | (pend & ~pend_clr);
  assign mask_nxt = wr_mask ? bus.cfg_wdata : mask;

  always_comb begin
    pend_clr = wr_pend ? bus.cfg_wdata : '0;
    isr_clr  = '0;
    isr_set  = '0;
    if (ack_take) begin
      pend_clr[num_q] = 1'b1;
      isr_set[num_q]  = 1'b1;
    end
    if (bus.eoi && isr_found)
      isr_clr[isr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask  <= '0;
      pend  <= '0;
      isr   <= '0;
      trig  <= '1;
      req_q <= '0;
    end else begin
      mask  <= mask_nxt;
      pend  <= pend_nxt;
      isr   <= (isr & ~isr_clr) | isr_set;
      req_q <= bus.int_req;
      if (wr_trig)
        trig <= bus.cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      vld_q <= 1'b0;
      num_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (win_found) begin
          state <= S_REQ;
          vld_q <= 1'b1;
          num_q <= win_idx;
        end
        default: if (ack_take || mask_nxt[num_q] || !pend_nxt[num_q]) begin
          state <= S_IDLE;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_vld = vld_q;
  assign bus.int_num = num_q;

  always_comb begin
    case (bus.cfg_addr)
      CFG_MASK: bus.cfg_rdata = mask;
      CFG_PEND: bus.cfg_rdata = pend;
      CFG_ISR:  bus.cfg_rdata = isr;
      default:  bus.cfg_rdata = trig;
    endcase
  end

endmodule

// File: tb/tb_pic_ctrl.sv
// Bench for pic_ctrl: per-cycle vector table, reset/rotation sequences, randomized run against a behavioural model.
module tb_pic_ctrl;
  import pic_pkg::*;

  localparam int N = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pic_ctrl_if #(.N_IRQ(N), .ID_W(W)) bus();
  pic_ctrl #(.N_IRQ(N), .ID_W(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic       eoi;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       exp_int;
    logic [2:0] exp_num;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] req, input logic ack, input logic eoi, input logic we,
                     input logic [1:0] addr, input logic [7:0] wdata,
                     input logic exp_int, input logic [2:0] exp_num, input logic [7:0] exp_rd);
    vec_t v;
    v.req = req; v.ack = ack; v.eoi = eoi; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_int = exp_int; v.exp_num = exp_num; v.exp_rd = exp_rd;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [7:0] req, input logic ack, input logic eoi, input logic we,
                       input logic [1:0] addr, input logic [7:0] wdata);
    bus.int_req   = req;
    bus.int_ack   = ack;
    bus.eoi       = eoi;
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wdata;
  endtask

  task automatic check(input string name, input logic exp_int, input logic [2:0] exp_num,
                       input logic [7:0] exp_rd);
    n_vec++;
    if (bus.int_vld !== exp_int || (exp_int && bus.int_num !== exp_num) || bus.cfg_rdata !== exp_rd) begin
      n_bad++;
      $display("FAIL %s: got int=%0b num=%0d rdata=%02h, want int=%0b num=%0d rdata=%02h",
               name, bus.int_vld, bus.int_num, bus.cfg_rdata, exp_int, exp_num, exp_rd);
    end
  endtask

  task automatic step(input logic [7:0] req, input logic ack, input logic eoi, input logic we,
                      input logic [1:0] addr, input logic [7:0] wdata);
    drive(req, ack, eoi, we, addr, wdata);
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_mask, m_pend, m_isr, m_trig, m_reqq;
  bit         m_on;
  int         m_num, m_base;

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_isr = '0; m_trig = '1; m_reqq = '0;
    m_on = 0; m_num = 0; m_base = 0;
  endtask

  function automatic int first_in_order(input logic [7:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_base + k) % N]) return (m_base + k) % N;
    return -1;
  endfunction

  function automatic logic [7:0] model_rd(input logic [1:0] a);
    case (a)
      CFG_MASK: return m_mask;
      CFG_PEND: return m_pend;
      CFG_ISR:  return m_isr;
      default:  return m_trig;
    endcase
  endfunction

  task automatic model_step(input logic [7:0] req, input logic ack, input logic eoi, input logic we,
                            input logic [1:0] addr, input logic [7:0] wdata);
    int top, win, lim;
    logic [7:0] np;
    logic set, clr;
    top = first_in_order(m_isr);
    lim = (top < 0) ? N : (top - m_base + N) % N;
    win = -1;
    for (int k = 0; k < lim; k++)
      if (win < 0 && m_pend[(m_base + k) % N] && !m_mask[(m_base + k) % N]) win = (m_base + k) % N;
    for (int i = 0; i < N; i++) begin
      set   = m_trig[i] ? (req[i] && !m_reqq[i]) : req[i];
      clr   = (we && addr == CFG_PEND && wdata[i]) || (ack && m_on && m_num == i);
      np[i] = set || (m_pend[i] && !clr);
    end
    if (we && addr == CFG_MASK) m_mask = wdata;
    if (we && addr == CFG_TRIG) m_trig = wdata;
    if (eoi && top >= 0) begin
      m_isr[top] = 1'b0;
`ifdef PIC_ROTATE_PRIO_EN
      m_base = (top + 1) % N;
`endif
    end
    if (m_on) begin
      if (ack) begin
        m_isr[m_num] = 1'b1;
        m_on = 0;
      end else if (m_mask[m_num] || !np[m_num]) begin
        m_on = 0;
      end
    end else if (win >= 0) begin
      m_on = 1;
      m_num = win;
    end
    m_pend = np;
    m_reqq = req;
  endtask

  task automatic do_reset();
    drive(8'h00, 0, 0, 0, CFG_MASK, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  logic [7:0] rst_exp [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r, wd;
    logic       a, e, w;
    logic [1:0] ad;

    drive(8'h00, 0, 0, 0, CFG_MASK, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_addr = 2'(i);
      #1;
      check($sformatf("reset_reg%0d", i), 1'b0, 3'd0, rst_exp[i]);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

`ifndef PIC_ROTATE_PRIO_EN
    // single pulse on line 5, ack, eoi
    add(8'h20,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h20);
    add(8'h00,0,0,0,CFG_ISR ,8'h00, 1,3'd5,8'h00);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 1,3'd5,8'h20);
    add(8'h00,1,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h20);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h00);
    add(8'h00,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    // lines 6 and 2 together; 6 blocked until eoi of 2
    add(8'h44,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h44);
    add(8'h44,0,0,0,CFG_PEND,8'h00, 1,3'd2,8'h44);
    add(8'h00,1,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h04);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h40);
    add(8'h00,0,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h04);
    add(8'h00,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 1,3'd6,8'h40);
    add(8'h00,1,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h40);
    add(8'h00,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    // nesting: 1 preempts 4, 7 waits for both eois
    add(8'h10,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h10);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 1,3'd4,8'h10);
    add(8'h00,1,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h10);
    add(8'h80,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h80);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h80);
    add(8'h02,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h82);
    add(8'h00,0,0,0,CFG_ISR ,8'h00, 1,3'd1,8'h10);
    add(8'h00,1,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h12);
    add(8'h00,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h10);
    add(8'h00,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 1,3'd7,8'h80);
    add(8'h00,1,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h80);
    add(8'h00,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    // mask holds line 3 pending; W1C and mask both withdraw a presented request
    add(8'h00,0,0,1,CFG_MASK,8'h08, 0,3'd0,8'h08);
    add(8'h08,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h08);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h08);
    add(8'h00,0,0,1,CFG_MASK,8'h00, 0,3'd0,8'h00);
    add(8'h00,0,0,0,CFG_ISR ,8'h00, 1,3'd3,8'h00);
    add(8'h00,0,0,1,CFG_PEND,8'h08, 0,3'd0,8'h00);
    add(8'h00,0,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    add(8'h08,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h08);
    add(8'h00,0,0,0,CFG_PEND,8'h00, 1,3'd3,8'h08);
    add(8'h00,0,0,1,CFG_MASK,8'h08, 0,3'd0,8'h08);
    add(8'h00,0,0,1,CFG_MASK,8'h00, 0,3'd0,8'h00);
    add(8'h00,0,0,0,CFG_ISR ,8'h00, 1,3'd3,8'h00);
    add(8'h00,1,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h08);
    add(8'h00,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    // level-triggered line 0 held high through ack
    add(8'h00,0,0,1,CFG_TRIG,8'hFE, 0,3'd0,8'hFE);
    add(8'h01,0,0,0,CFG_PEND,8'h00, 0,3'd0,8'h01);
    add(8'h01,0,0,0,CFG_PEND,8'h00, 1,3'd0,8'h01);
    add(8'h01,1,0,0,CFG_PEND,8'h00, 0,3'd0,8'h01);
    add(8'h01,0,0,0,CFG_ISR ,8'h00, 0,3'd0,8'h01);
    add(8'h01,0,1,0,CFG_ISR ,8'h00, 0,3'd0,8'h00);
    add(8'h01,0,0,0,CFG_PEND,8'h00, 1,3'd0,8'h01);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].ack, tbl[i].eoi, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      check($sformatf("vec%0d", i), tbl[i].exp_int, tbl[i].exp_num, tbl[i].exp_rd);
    end

    // asynchronous reset while int is high
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_addr = 2'(i);
      #1;
      check($sformatf("async_rst_reg%0d", i), 1'b0, 3'd0, rst_exp[i]);
    end
    do_reset();
`else
    // rotated order: after servicing line 0, line 1 outranks line 0
    step(8'h01,0,0,0,CFG_PEND,8'h00); check("rot_pend0", 1'b0, 3'd0, 8'h01);
    step(8'h00,0,0,0,CFG_ISR ,8'h00); check("rot_int0",  1'b1, 3'd0, 8'h00);
    step(8'h00,1,0,0,CFG_ISR ,8'h00); check("rot_ack0",  1'b0, 3'd0, 8'h01);
    step(8'h00,0,1,0,CFG_ISR ,8'h00); check("rot_eoi0",  1'b0, 3'd0, 8'h00);
    step(8'h03,0,0,0,CFG_PEND,8'h00); check("rot_pend01",1'b0, 3'd0, 8'h03);
    step(8'h00,0,0,0,CFG_PEND,8'h00); check("rot_win1",  1'b1, 3'd1, 8'h03);
    do_reset();
`endif

    for (int c = 0; c < 600; c++) begin
      r  = 8'($urandom & $urandom & $urandom);
      a  = ($urandom_range(0, 2) == 0);
      e  = ($urandom_range(0, 5) == 0);
      w  = ($urandom_range(0, 9) == 0);
      ad = 2'($urandom_range(0, 3));
      wd = (ad == CFG_MASK) ? 8'($urandom & $urandom) : 8'($urandom);
      drive(r, a, e, w, ad, wd);
      model_step(r, a, e, w, ad, wd);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d", c), m_on, 3'(m_num), model_rd(ad));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
